// File: rtl/aggregating_results_arbiter.sv
// aggregating_results_arbiter: round-robin collector of per-pipe result FIFOs into one
// tagged output stream, with credit-checked grabs so the output buffer never overflows.
module aggregating_results_arbiter #(
    parameter int NUM_PIPES             = 4,
    parameter int PCOEFF_COUNT_BITWIDTH = 10,
    parameter int READ_LATENCY          = 2,
    parameter int BUF_DEPTH_LOG2        = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [NUM_PIPES-1:0]                                 resultsAvailable,
    output logic [NUM_PIPES-1:0]                                 grabResults,
    input  logic [NUM_PIPES*(PCOEFF_COUNT_BITWIDTH+35)-1:0]      pcoeffSumIn,
    input  logic [NUM_PIPES*PCOEFF_COUNT_BITWIDTH-1:0]           pcoeffCountIn,
    output logic                                                 outValid,
    input  logic                                                 outReady,
    output logic [3:0]                                           outPipeIndex,
    output logic [PCOEFF_COUNT_BITWIDTH+34:0]                    outPcoeffSum,
    output logic [PCOEFF_COUNT_BITWIDTH-1:0]                     outPcoeffCount,
    output logic [31:0]                                          resultsCollected
);
    localparam int SW    = PCOEFF_COUNT_BITWIDTH + 35;
    localparam int CW    = PCOEFF_COUNT_BITWIDTH;
    localparam int EW    = 4 + SW + CW;
    localparam int AW    = BUF_DEPTH_LOG2;
    localparam int DEPTH = 1 << BUF_DEPTH_LOG2;

    logic [NUM_PIPES-1:0] r_grab;
    logic [3:0]           r_gidx;
    logic [3:0]           r_ptr;
    logic [READ_LATENCY-1:0] r_dv;
    logic [3:0]           r_di [READ_LATENCY];
    logic [EW-1:0]        r_mem [DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_cnt, r_infl;
    logic [31:0]          r_collected;

    logic                 w_credit, w_gnt, w_push, w_pop;
    logic [NUM_PIPES-1:0] w_elig, w_rot;
    logic [3:0]           w_sel, w_ptr_nxt, w_idx;
    logic [EW-1:0]        w_head, w_in;

    // In-flight grants hold a buffer slot from decision until their word is popped.
    assign w_credit  = ({1'b0, r_cnt} + {1'b0, r_infl}) < (AW+2)'(DEPTH);
    assign w_elig    = resultsAvailable & ~r_grab & {NUM_PIPES{w_credit}};
    assign w_rot     = NUM_PIPES'({w_elig, w_elig} >> r_ptr);
    assign w_ptr_nxt = (w_sel == 4'(NUM_PIPES-1)) ? 4'd0 : w_sel + 4'd1;

    always_comb begin
        w_gnt = 1'b0;
        w_sel = '0;
        for (int k = NUM_PIPES-1; k >= 0; k--)
            if (w_rot[k]) begin
                w_gnt = 1'b1;
                w_sel = (5'(r_ptr) + 5'(k) >= 5'(NUM_PIPES)) ? 4'(5'(r_ptr) + 5'(k) - 5'(NUM_PIPES))
                                                             : 4'(5'(r_ptr) + 5'(k));
            end
    end

    assign w_idx    = r_di[READ_LATENCY-1];
    assign w_push   = r_dv[READ_LATENCY-1];
    assign w_in     = {w_idx, pcoeffSumIn[w_idx*SW +: SW], pcoeffCountIn[w_idx*CW +: CW]};
    assign outValid = r_cnt != '0;
    assign w_pop    = outValid && outReady;
    assign w_head   = r_mem[r_rptr];

    assign grabResults      = r_grab;
    assign resultsCollected = r_collected;
    assign {outPipeIndex, outPcoeffSum, outPcoeffCount} = outValid ? w_head : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grab      <= '0;
            r_gidx      <= '0;
            r_ptr       <= '0;
            r_dv        <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_infl      <= '0;
            r_collected <= '0;
        end else begin
            r_grab      <= w_gnt ? NUM_PIPES'(1) << w_sel : '0;
            r_gidx      <= w_sel;
            r_ptr       <= w_gnt ? w_ptr_nxt : r_ptr;
            r_dv[0]     <= |r_grab;
            for (int k = 1; k < READ_LATENCY; k++)
                r_dv[k] <= r_dv[k-1];
            r_wptr      <= r_wptr + AW'(w_push);
            r_rptr      <= r_rptr + AW'(w_pop);
            r_cnt       <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_infl      <= r_infl + (AW+1)'(w_gnt) - (AW+1)'(w_push);
            r_collected <= r_collected + 32'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        r_di[0] <= r_gidx;
        for (int k = 1; k < READ_LATENCY; k++)
            r_di[k] <= r_di[k-1];
        if (w_push)
            r_mem[r_wptr] <= w_in;
    end

    assert property (@(posedge clk) disable iff (!rst_n) w_push |-> r_cnt != (AW+1)'(DEPTH))
        else $error("push into full result buffer");
endmodule

// File: doc/aggregating_results_arbiter.md
Name: aggregating_results_arbiter

Overview:
- Collects finished-batch results from NUM_PIPES aggregating pipelines, each fronted by its own output result FIFO, into one tagged output stream.
- Issues one-cycle grabResults pulses round-robin and tracks reads in flight through the FIFO read latency.
- Buffers returned words so downstream backpressure never loses data.
- Sits between the pipeline bank and the host/PCIe result writer.

Parameters:
- NUM_PIPES, 4, number of pipelines served (1..16)
- PCOEFF_COUNT_BITWIDTH, 10, count width; sum width is PCOEFF_COUNT_BITWIDTH+35
- READ_LATENCY, 2, cycles from grabResults pulse to valid pcoeffSum/pcoeffCount at the pipeline output (1..4)
- BUF_DEPTH_LOG2, 3, log2 of the internal output buffer depth

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  synchronous reset, active-low
- resultsAvailable  in  NUM_PIPES  per-pipe result FIFO non-empty
- grabResults  out  NUM_PIPES  per-pipe one-cycle read pulse
- pcoeffSumIn  in  NUM_PIPES*(PCOEFF_COUNT_BITWIDTH+35)  per-pipe sum; pipe i occupies slice i
- pcoeffCountIn  in  NUM_PIPES*PCOEFF_COUNT_BITWIDTH  per-pipe count
- outValid  out  1  output word valid
- outReady  in  1  downstream accepts the word when outValid && outReady
- outPipeIndex  out  4  source pipe of the output word
- outPcoeffSum  out  PCOEFF_COUNT_BITWIDTH+35  sum
- outPcoeffCount  out  PCOEFF_COUNT_BITWIDTH  count
- resultsCollected  out  32  total words accepted downstream, wraps modulo 2^32

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - grabResults=0, outValid=0, outPipeIndex/outPcoeffSum/outPcoeffCount=0, resultsCollected=0.
  - Round-robin pointer=0, buffer empty, in-flight pipeline cleared.
  - Reads in flight at reset are discarded. Assertion mid-operation is allowed; the lost words are the system's concern.
- Eligibility of pipe i in cycle t:
  - resultsAvailable[i]=1;
  - pipe i was not granted in cycle t-1 (holdoff covers the FIFO empty-flag update lag);
  - credit check: bufCount + inFlight < 2^BUF_DEPTH_LOG2. inFlight counts grants not yet written to the buffer; bufCount is evaluated before this cycle's pop.
- Arbitration:
  - At most one grant per cycle, chosen round-robin starting at the pointer.
  - The granted pipe gets grabResults[i]=1 registered, i.e. in cycle t+1 after the decision in cycle t.
  - The pointer then moves to granted index+1, wrapping NUM_PIPES-1 -> 0.
  - No eligible pipe: no grant, pointer unchanged.
- Return path:
  - A delay line of READ_LATENCY entries (valid + 4-bit index) tracks each pulse.
  - On delay-line exit, the block samples slice[index] of pcoeffSumIn/pcoeffCountIn and pushes it into the buffer in the same cycle.
  - The credit check guarantees the push never finds the buffer full; a push on full is a design error and must be covered by a simulation assertion.
- Output buffer:
  - First-word-fall-through FIFO; outValid = !empty.
  - Pop on outValid && outReady. Push and pop in the same cycle are both honoured and count is unchanged.
  - Data must be held stable while outValid && !outReady.
- Latency: resultsAvailable rising with an idle arbiter and empty buffer -> grab pulse 1 cycle later -> outValid READ_LATENCY+1 cycles after the pulse.
- Throughput:
  - Sustained 1 word/cycle needs at least 2 pipes available, because of the holdoff.
  - A single pipe is served every other cycle.
- resultsCollected increments on every accepted output word (outValid && outReady).

Test Plan:
- Reset then idle, resultsAvailable=0 -> grabResults stays 0 and outValid stays 0 for 100 cycles; resultsCollected=0.
- NUM_PIPES=4, all resultsAvailable=1, outReady=1 -> grabs pulse in order pipe 0,1,2,3,0,... one per cycle; outPipeIndex follows the same order; resultsCollected=40 after 40 accepts.
- Only pipe 2 available, FIFO holding 3 entries with sums 100/200/300 -> three grabs on alternating cycles; outputs 100,200,300 tagged with index 2; no fourth grab after resultsAvailable[2] drops.
- outReady=0 with all pipes available -> exactly 8 grabs issued (BUF_DEPTH_LOG2=3), then grabs stop; raise outReady -> 8 words drain in grant order, then grabbing resumes.
- Toggle outReady randomly for 10k cycles against an ideal FIFO model per pipe -> per-pipe output order preserved; no loss or duplication; the push-on-full assertion never fires.
- Assert rst_n=0 for 1 cycle while 2 reads are in flight and the buffer holds 3 words -> the next cycle shows outValid=0 and resultsCollected=0; the in-flight words are not emitted.
